// File: rtl/bcd_pkg.sv
// Shared types and constants for the multi-channel binary-to-BCD converter.
package bcd_pkg;

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, STORE} state_t;

   localparam int unsigned DIGW    = 4;
   localparam logic [3:0]  BCD_MAX = 4'd9;

   // Digits needed to hold any WIDTH-bit value exactly (log10(2) ~ 0.301).
   function automatic int unsigned nfull(input int unsigned width);
      return (width * 301) / 1000 + 1;
   endfunction

endpackage

// File: rtl/dd_step.sv
// One double-dabble iteration: add-3 to every digit >= 5, then shift in one bit.
module dd_step
   import bcd_pkg::*;
#(
   parameter int unsigned NF = 4
)(
   input  logic [NF*DIGW-1:0] scr_in,
   input  logic               bit_in,
   output logic [NF*DIGW-1:0] scr_out
);

   logic [NF*DIGW-1:0] adj;

   always_comb begin
      adj = scr_in;
      for (int unsigned i = 0; i < NF; i++)
         if (scr_in[i*DIGW +: DIGW] >= 4'd5)
            adj[i*DIGW +: DIGW] = scr_in[i*DIGW +: DIGW] + 4'd3;
      scr_out = {adj[NF*DIGW-2:0], bit_in};
   end

endmodule

// File: rtl/bcd_conv_multi.sv
// Round-robin multi-channel binary-to-BCD converter with per-channel overflow
// saturation, leading-zero blanking and a completion strobe.
module bcd_conv_multi
   import bcd_pkg::*;
#(
   parameter int unsigned NCH   = 2,
   parameter int unsigned WIDTH = 12,
   parameter int unsigned NDIG  = 4
)(
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NCH*WIDTH-1:0]   bin_in,
   input  logic                   cont,
   input  logic                   start,
   output logic [NCH*NDIG*4-1:0]  bcd_out,
   output logic [NCH-1:0]         ovf,
   output logic [NCH*NDIG-1:0]    blank,
   output logic                   done_strb,
   output logic [2:0]             done_ch,
   output logic                   busy
);

   localparam int unsigned NF = nfull(WIDTH);
   localparam int unsigned NX = (NF > NDIG) ? NF : NDIG;
   localparam int unsigned CW = $clog2(WIDTH);

   state_t               state;
   logic [2:0]           ch_idx;
   logic [CW-1:0]        bitcnt;
   logic [WIDTH-1:0]     sr;
   logic [WIDTH-1:0]     sel;
   logic [NF*DIGW-1:0]   scr;
   logic [NF*DIGW-1:0]   scr_nxt;
   logic [NX*DIGW-1:0]   scr_ext;
   logic [NDIG*DIGW-1:0] dig_c;
   logic [NDIG-1:0]      blank_c;
   logic                 ovf_c;
   logic                 zrun;

   always_comb begin
      sel = '0;
      for (int unsigned k = 0; k < NCH; k++)
         if (ch_idx == 3'(k))
            sel = bin_in[k*WIDTH +: WIDTH];
   end

   dd_step #(.NF(NF)) u_step (
      .scr_in  (scr),
      .bit_in  (sr[WIDTH-1]),
      .scr_out (scr_nxt)
   );

   // Scratch is widened to max(NF, NDIG) digits so NDIG > NF presents zeros.
   always_comb begin
      scr_ext = '0;
      scr_ext[NF*DIGW-1:0] = scr;
      ovf_c = 1'b0;
      for (int unsigned i = NDIG; i < NX; i++)
         if (scr_ext[i*DIGW +: DIGW] != '0)
            ovf_c = 1'b1;
      dig_c   = ovf_c ? {NDIG{BCD_MAX}} : scr_ext[NDIG*DIGW-1:0];
      blank_c = '0;
      zrun    = 1'b1;
      for (int unsigned k = 0; k + 1 < NDIG; k++) begin
         zrun = zrun & (scr_ext[(NDIG-1-k)*DIGW +: DIGW] == '0);
         blank_c[NDIG-1-k] = zrun & ~ovf_c;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         ch_idx    <= '0;
         bitcnt    <= '0;
         sr        <= '0;
         scr       <= '0;
         bcd_out   <= '0;
         ovf       <= '0;
         blank     <= '0;
         done_strb <= 1'b0;
         done_ch   <= '0;
         busy      <= 1'b0;
      end else begin
         done_strb <= 1'b0;
         case (state)
            IDLE: begin
               if (cont || start) begin
                  state  <= LOAD;
                  ch_idx <= '0;
                  busy   <= 1'b1;
               end
            end
            LOAD: begin
               sr     <= sel;
               scr    <= '0;
               bitcnt <= '0;
               state  <= SHIFT;
            end
            SHIFT: begin
               sr     <= sr << 1;
               scr    <= scr_nxt;
               bitcnt <= bitcnt + CW'(1);
               if (bitcnt == CW'(WIDTH-1))
                  state <= STORE;
            end
            STORE: begin
               for (int unsigned k = 0; k < NCH; k++)
                  if (ch_idx == 3'(k)) begin
                     bcd_out[k*NDIG*DIGW +: NDIG*DIGW] <= dig_c;
                     ovf[k]                            <= ovf_c;
                     blank[k*NDIG +: NDIG]             <= blank_c;
                  end
               done_strb <= 1'b1;
               done_ch   <= ch_idx;
               if (ch_idx != 3'(NCH-1)) begin
                  ch_idx <= ch_idx + 3'd1;
                  state  <= LOAD;
               end else begin
                  ch_idx <= '0;
                  if (cont) begin
                     state <= LOAD;
                  end else begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bcd_conv_multi.sv
// Scoreboard bench for bcd_conv_multi: three configurations, directed vectors.
module tb_bcd_conv_multi;

   typedef struct {
      int         ch;
      logic [31:0] dig;
      logic [7:0]  blk;
      logic        ov;
      int          cyc;
   } exp_t;

   exp_t q[3][$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   t0;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // u0: defaults
   logic [23:0] bin0 = '0;
   logic        co0 = 1'b0, st0 = 1'b0;
   logic [31:0] bcd0;
   logic [1:0]  ovf0;
   logic [7:0]  blk0;
   logic        ds0, busy0;
   logic [2:0]  dc0;
   // u1: NDIG=3
   logic [23:0] bin1 = '0;
   logic        co1 = 1'b0, st1 = 1'b0;
   logic [23:0] bcd1;
   logic [1:0]  ovf1;
   logic [5:0]  blk1;
   logic        ds1, busy1;
   logic [2:0]  dc1;
   // u2: NCH=3 WIDTH=20 NDIG=7
   logic [59:0] bin2 = '0;
   logic        co2 = 1'b0, st2 = 1'b0;
   logic [83:0] bcd2;
   logic [2:0]  ovf2;
   logic [20:0] blk2;
   logic        ds2, busy2;
   logic [2:0]  dc2;

   bcd_conv_multi u0 (
      .clk(clk), .rst(rst), .bin_in(bin0), .cont(co0), .start(st0),
      .bcd_out(bcd0), .ovf(ovf0), .blank(blk0), .done_strb(ds0),
      .done_ch(dc0), .busy(busy0)
   );

   bcd_conv_multi #(.NDIG(3)) u1 (
      .clk(clk), .rst(rst), .bin_in(bin1), .cont(co1), .start(st1),
      .bcd_out(bcd1), .ovf(ovf1), .blank(blk1), .done_strb(ds1),
      .done_ch(dc1), .busy(busy1)
   );

   bcd_conv_multi #(.NCH(3), .WIDTH(20), .NDIG(7)) u2 (
      .clk(clk), .rst(rst), .bin_in(bin2), .cont(co2), .start(st2),
      .bcd_out(bcd2), .ovf(ovf2), .blank(blk2), .done_strb(ds2),
      .done_ch(dc2), .busy(busy2)
   );

   function automatic logic [31:0] get_dig(input logic [255:0] bus, input int ch, input int nd);
      logic [31:0] r = '0;
      for (int d = 0; d < nd; d++)
         r[d*4 +: 4] = bus[(ch*nd+d)*4 +: 4];
      return r;
   endfunction

   function automatic logic [7:0] get_blk(input logic [63:0] bus, input int ch, input int nd);
      logic [7:0] r = '0;
      for (int d = 0; d < nd; d++)
         r[d] = bus[ch*nd+d];
      return r;
   endfunction

   task automatic push(input int id, input int ch, input logic [31:0] dig,
                       input logic [7:0] blk, input logic ov, input int c);
      exp_t e;
      e.ch = ch; e.dig = dig; e.blk = blk; e.ov = ov; e.cyc = c;
      q[id].push_back(e);
   endtask

   task automatic score(input int id, input int ch, input logic [31:0] dig,
                        input logic [7:0] blk, input logic [7:0] ovbus);
      exp_t e;
      checks++;
      if (q[id].size() == 0) begin
         errors++;
         $display("FAIL dut%0d_strobe: unexpected done_strb ch=%0d at cyc=%0d, required none", id, ch, cyc);
         return;
      end
      e = q[id].pop_front();
      if (ch != e.ch || dig !== e.dig || blk !== e.blk || ovbus[ch] !== e.ov || cyc != e.cyc) begin
         errors++;
         $display("FAIL dut%0d_result: got ch=%0d dig=%h blank=%b ovf=%b cyc=%0d, required ch=%0d dig=%h blank=%b ovf=%b cyc=%0d",
                  id, ch, dig, blk, ovbus[ch], cyc, e.ch, e.dig, e.blk, e.ov, e.cyc);
      end
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   task automatic wait_to(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   always @(negedge clk)
      if (ds0) score(0, int'(dc0), get_dig(256'(bcd0), int'(dc0), 4), get_blk(64'(blk0), int'(dc0), 4), 8'(ovf0));
   always @(negedge clk)
      if (ds1) score(1, int'(dc1), get_dig(256'(bcd1), int'(dc1), 3), get_blk(64'(blk1), int'(dc1), 3), 8'(ovf1));
   always @(negedge clk)
      if (ds2) score(2, int'(dc2), get_dig(256'(bcd2), int'(dc2), 7), get_blk(64'(blk2), int'(dc2), 7), 8'(ovf2));

   initial begin
      // reset state
      repeat (2) @(negedge clk);
      chk("rst_bcd", 64'(bcd0), 64'h0);
      chk("rst_busy", 64'(busy0), 64'h0);
      chk("rst_blank", 64'(blk0), 64'h0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // one-shot sweep, start while busy ignored
      bin0 = {12'd0, 12'd4095};
      t0 = cyc;
      push(0, 0, 32'h4095, 8'b0000, 1'b0, t0 + 15);
      push(0, 1, 32'h0000, 8'b1110, 1'b0, t0 + 29);
      st0 = 1'b1; @(negedge clk); st0 = 1'b0;
      wait_to(t0 + 6);
      chk("busy_mid", 64'(busy0), 64'h1);
      st0 = 1'b1; @(negedge clk); st0 = 1'b0;
      wait_to(t0 + 32);
      chk("busy_after", 64'(busy0), 64'h0);

      // NDIG=3 overflow saturation
      bin1 = {12'd999, 12'd4095};
      t0 = cyc;
      push(1, 0, 32'h999, 8'b000, 1'b1, t0 + 15);
      push(1, 1, 32'h999, 8'b000, 1'b0, t0 + 29);
      st1 = 1'b1; @(negedge clk); st1 = 1'b0;
      wait_to(t0 + 32);

      // continuous mode, input change mid-SHIFT, start ignored, cont drop
      bin0 = {12'd56, 12'd1234};
      t0 = cyc;
      push(0, 0, 32'h1234, 8'b0000, 1'b0, t0 + 15);
      push(0, 1, 32'h0056, 8'b1100, 1'b0, t0 + 29);
      push(0, 0, 32'h0007, 8'b1110, 1'b0, t0 + 43);
      push(0, 1, 32'h0056, 8'b1100, 1'b0, t0 + 57);
      co0 = 1'b1;
      wait_to(t0 + 6);
      bin0[11:0] = 12'd7;
      wait_to(t0 + 20);
      st0 = 1'b1; @(negedge clk); st0 = 1'b0;
      wait_to(t0 + 45);
      co0 = 1'b0;
      wait_to(t0 + 60);
      chk("cont_idle", 64'(busy0), 64'h0);

      // reset during SHIFT of ch1, then a clean conversion
      bin0 = {12'd200, 12'd100};
      t0 = cyc;
      push(0, 0, 32'h0100, 8'b1000, 1'b0, t0 + 15);
      st0 = 1'b1; @(negedge clk); st0 = 1'b0;
      wait_to(t0 + 20);
      rst = 1'b1; @(negedge clk); rst = 1'b0;
      chk("mid_rst_bcd", 64'(bcd0), 64'h0);
      chk("mid_rst_ovf", 64'(ovf0), 64'h0);
      chk("mid_rst_blank", 64'(blk0), 64'h0);
      chk("mid_rst_busy", 64'(busy0), 64'h0);
      chk("mid_rst_strb", 64'(ds0), 64'h0);
      repeat (3) @(negedge clk);
      bin0 = {12'd8, 12'd321};
      t0 = cyc;
      push(0, 0, 32'h0321, 8'b1000, 1'b0, t0 + 15);
      push(0, 1, 32'h0008, 8'b1110, 1'b0, t0 + 29);
      st0 = 1'b1; @(negedge clk); st0 = 1'b0;
      wait_to(t0 + 32);
      chk("post_rst_busy", 64'(busy0), 64'h0);

      // WIDTH=20, NCH=3, NDIG=7
      bin2 = {20'd9, 20'd100000, 20'd1048575};
      t0 = cyc;
      push(2, 0, 32'h1048575, 8'b0000000, 1'b0, t0 + 23);
      push(2, 1, 32'h0100000, 8'b1000000, 1'b0, t0 + 45);
      push(2, 2, 32'h0000009, 8'b1111110, 1'b0, t0 + 67);
      st2 = 1'b1; @(negedge clk); st2 = 1'b0;
      wait_to(t0 + 70);
      chk("w20_busy", 64'(busy2), 64'h0);

      repeat (4) @(negedge clk);
      for (int i = 0; i < 3; i++)
         chk($sformatf("dut%0d_pending", i), 64'(q[i].size()), 64'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
